key_led_ctrl: RTL

Per-key debounced mode controller that drives the 4-LED bank from the 4 on-board push keys. Each key is synchronized and debounced, and each clean press advances its LED through OFF -> ON -> BLINK -> OFF. It sits between the raw key pins and the LED pins and replaces the direct key-to-LED path. It also exports press pulses and mode state for other logic.

---
 rtl/key_led_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/key_led_ctrl.sv
// Debounced per-key LED mode controller: each clean press steps its LED
// through OFF -> ON -> BLINK -> OFF; press pulses and modes are exported.
module key_led_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLINK_HALF      = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key,
    output logic [3:0] led,
    output logic [3:0] key_press,
    output logic [7:0] led_mode
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int BW = $clog2(BLINK_HALF);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10
    } mode_t;

    logic [3:0]    s1;
    logic [3:0]    s2;
    logic [3:0]    stable;
    logic [3:0]    stable_q;
    logic [CW-1:0] cnt [4];
    logic [BW-1:0] bcnt;
    logic          blink_phase;
    mode_t         mode [4];

    // Keys are active-low; the synchronizer works on the pressed level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1       <= '0;
            s2       <= '0;
            stable   <= '0;
            stable_q <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1       <= ~key;
            s2       <= s1;
            stable_q <= stable;
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_press <= '0;
        end else begin
            key_press <= stable & ~stable_q;
        end
    end

    // Free-running so every blinking LED shares one phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt        <= '0;
            blink_phase <= 1'b0;
        end else if (bcnt == BLINK_LAST) begin
            bcnt        <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            bcnt <= bcnt + BW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mode[i] <= MODE_OFF;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                case (mode[i])
                    MODE_OFF:   if (key_press[i]) mode[i] <= MODE_ON;
                    MODE_ON:    if (key_press[i]) mode[i] <= MODE_BLINK;
                    MODE_BLINK: if (key_press[i]) mode[i] <= MODE_OFF;
                    default:    mode[i] <= MODE_OFF;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                case (mode[i])
                    MODE_ON:    led[i] <= 1'b1;
                    MODE_BLINK: led[i] <= blink_phase;
                    default:    led[i] <= 1'b0;
                endcase
            end
        end
    end

    assign led_mode = {mode[3], mode[2], mode[1], mode[0]};

endmodule
